// File: rtl/text_render.sv
// ---------------------------------------------------------------------------
// text_render
// Character-cell text renderer for a VGA-style timing stream.
// The incoming timing is delayed by four clocks while the cell attributes are
// fetched from VRAM and the glyph line from the glyph ROM. The glyph line is
// serialised MSB first and mapped to RGB565-style output colour.
//
// Ports
//   clk, reset                 pixel clock, synchronous active-high reset
//   in_hsync/in_vsync/in_de    timing from the vga generator
//   in_row_first, in_row_start frame-start / text-row-start pulses
//   in_row_pixel               glyph line within the current text row
//   in_col_start, in_col_index first pixel of a cell and its column
//   cursor_enable/row/col      cursor control
//   vram_ce/row/col, vram_data VRAM read port (data one clock after strobe)
//   rom_ce/char/row, rom_q     glyph ROM read port (data one clock after strobe)
//   lcd_hsync/vsync/de         timing delayed by four clocks
//   lcd_r/g/b                  pixel colour, zero outside the active area
// ---------------------------------------------------------------------------
module text_render #(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int CHAR_W       = 10,
   parameter int CHAR_H       = 16,
   parameter int COL_BITS     = 7,
   parameter int ROW_BITS     = 5,
   parameter int PIX_BITS     = 5,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_hsync,
   input  logic                in_vsync,
   input  logic                in_de,
   input  logic                in_row_first,
   input  logic                in_row_start,
   input  logic [PIX_BITS-1:0] in_row_pixel,
   input  logic                in_col_start,
   input  logic [COL_BITS-1:0] in_col_index,
   input  logic                cursor_enable,
   input  logic [ROW_BITS-1:0] cursor_row,
   input  logic [COL_BITS-1:0] cursor_col,
   output logic                vram_ce,
   output logic [ROW_BITS-1:0] vram_row,
   output logic [COL_BITS-1:0] vram_col,
   input  logic [15:0]         vram_data,
   output logic                rom_ce,
   output logic [7:0]          rom_char,
   output logic [PIX_BITS-1:0] rom_row,
   input  logic [CHAR_W-1:0]   rom_q,
   output logic                lcd_hsync,
   output logic                lcd_vsync,
   output logic                lcd_de,
   output logic [4:0]          lcd_r,
   output logic [5:0]          lcd_g,
   output logic [4:0]          lcd_b
);

   localparam int                   FRAME_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [ROW_BITS-1:0]   ROW_LAST   = ROW_BITS'(ROWS - 1);
   localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(BLINK_FRAMES - 1);
   localparam logic [PIX_BITS-1:0]   CUR_LINE   = PIX_BITS'(CHAR_H - 2);
   localparam logic [COL_BITS:0]     COL_LIMIT  = (COL_BITS + 1)'(COLS);

   function automatic logic [ROW_BITS-1:0] row_sat_inc(input logic [ROW_BITS-1:0] row);
      return (row >= ROW_LAST) ? ROW_LAST : row + 1'b1;
   endfunction

   function automatic logic [4:0] level5(input logic intense, input logic on);
      return on ? (intense ? 5'h1F : 5'h10) : 5'h00;
   endfunction

   function automatic logic [5:0] level6(input logic intense, input logic on);
      return on ? (intense ? 6'h3F : 6'h20) : 6'h00;
   endfunction

   logic [ROW_BITS-1:0]   r_row;
   logic [FRAME_BITS-1:0] r_frame;
   logic                  r_blink_phase;

   // timing bundles are {hsync, vsync, de}
   logic [2:0]            r_tim_p1, r_tim_p2, r_tim_p3, r_tim_p4;
   logic                  r_cs_p1, r_cs_p2, r_cs_p3;
   logic [COL_BITS-1:0]   r_col_p1;
   logic [PIX_BITS-1:0]   r_pix_p1, r_pix_p2, r_pix_p3, r_pix_p4;
   logic                  r_hit_p2, r_hit_p3, r_hit_p4;
   logic [7:0]            r_attr_p3, r_attr_p4;
   logic [CHAR_W-1:0]     r_shift_p4;

   logic                  w_hit_p1;
   logic                  w_cursor;
   logic                  w_pixel;
   logic [3:0]            w_irgb;

   // Row counter doubles as the stage-1 VRAM row; blink runs off frame starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_row         <= '0;
         r_frame       <= '0;
         r_blink_phase <= 1'b1;
      end else begin
         if (in_row_first) begin
            r_row <= '0;
         end else if (in_row_start) begin
            r_row <= row_sat_inc(r_row);
         end
         if (in_row_first) begin
            if (r_frame == FRAME_LAST) begin
               r_frame       <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_frame <= r_frame + 1'b1;
            end
         end
      end
   end

   // Columns past the last text column never carry the cursor.
   assign w_hit_p1 = (r_row == cursor_row) && (r_col_p1 == cursor_col) &&
                     ({1'b0, r_col_p1} < COL_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tim_p1   <= '0;
         r_cs_p1    <= 1'b0;
         r_col_p1   <= '0;
         r_pix_p1   <= '0;
         r_tim_p2   <= '0;
         r_cs_p2    <= 1'b0;
         r_pix_p2   <= '0;
         r_hit_p2   <= 1'b0;
         r_tim_p3   <= '0;
         r_cs_p3    <= 1'b0;
         r_pix_p3   <= '0;
         r_hit_p3   <= 1'b0;
         r_attr_p3  <= '0;
         r_tim_p4   <= '0;
         r_pix_p4   <= '0;
         r_hit_p4   <= 1'b0;
         r_attr_p4  <= '0;
         r_shift_p4 <= '0;
      end else begin
         // stage 1: VRAM address
         r_tim_p1 <= {in_hsync, in_vsync, in_de};
         r_cs_p1  <= in_col_start;
         r_col_p1 <= in_col_index;
         r_pix_p1 <= in_row_pixel;
         // stage 2: VRAM data returns, glyph ROM strobe
         r_tim_p2 <= r_tim_p1;
         r_cs_p2  <= r_cs_p1;
         r_pix_p2 <= r_pix_p1;
         r_hit_p2 <= w_hit_p1;
         // stage 3: attributes captured, glyph ROM data returns
         r_tim_p3  <= r_tim_p2;
         r_cs_p3   <= r_cs_p2;
         r_pix_p3  <= r_pix_p2;
         r_hit_p3  <= r_hit_p2;
         r_attr_p3 <= vram_data[15:8];
         // stage 4: glyph serialiser
         r_tim_p4 <= r_tim_p3;
         r_pix_p4 <= r_pix_p3;
         if (r_cs_p3) begin
            r_shift_p4 <= rom_q;
            r_attr_p4  <= r_attr_p3;
            r_hit_p4   <= r_hit_p3;
         end else begin
            r_shift_p4 <= {r_shift_p4[CHAR_W-2:0], 1'b0};
         end
      end
   end

   // Cursor underline inverts the glyph on the bottom two lines; a blinking
   // cell in the off phase shows background regardless of glyph or cursor.
   always_comb begin
      w_cursor = cursor_enable & r_hit_p4 & r_blink_phase & (r_pix_p4 >= CUR_LINE);
      w_pixel  = r_shift_p4[CHAR_W-1] ^ w_cursor;
      if (r_attr_p4[7] && !r_blink_phase) begin
         w_pixel = 1'b0;
      end
      w_irgb = w_pixel ? r_attr_p4[3:0] : {1'b0, r_attr_p4[6:4]};
      lcd_r  = '0;
      lcd_g  = '0;
      lcd_b  = '0;
      if (r_tim_p4[0]) begin
         lcd_r = level5(w_irgb[3], w_irgb[2]);
         lcd_g = level6(w_irgb[3], w_irgb[1]);
         lcd_b = level5(w_irgb[3], w_irgb[0]);
      end
   end

   assign vram_ce   = r_cs_p1;
   assign vram_row  = r_row;
   assign vram_col  = r_col_p1;
   assign rom_ce    = r_cs_p2;
   assign rom_char  = r_cs_p2 ? vram_data[7:0] : 8'h00;
   assign rom_row   = r_pix_p2;
   assign lcd_hsync = r_tim_p4[2];
   assign lcd_vsync = r_tim_p4[1];
   assign lcd_de    = r_tim_p4[0];

endmodule

// File: tb/tb_text_render.sv
module tb_text_render;
   localparam int COLS = 80, ROWS = 30, CHAR_W = 10, CHAR_H = 16;
   localparam int COL_BITS = 7, ROW_BITS = 5, PIX_BITS = 5, BLINK_FRAMES = 30;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_hsync, in_vsync, in_de, in_row_first, in_row_start;
   logic [PIX_BITS-1:0] in_row_pixel;
   logic                in_col_start;
   logic [COL_BITS-1:0] in_col_index;
   logic                cursor_enable;
   logic [ROW_BITS-1:0] cursor_row;
   logic [COL_BITS-1:0] cursor_col;
   logic                vram_ce;
   logic [ROW_BITS-1:0] vram_row;
   logic [COL_BITS-1:0] vram_col;
   logic [15:0]         vram_data = 16'h0000;
   logic                rom_ce;
   logic [7:0]          rom_char;
   logic [PIX_BITS-1:0] rom_row;
   logic [CHAR_W-1:0]   rom_q = '0;
   logic                lcd_hsync, lcd_vsync, lcd_de;
   logic [4:0]          lcd_r, lcd_b;
   logic [5:0]          lcd_g;

   always #5 clk = ~clk;

   text_render dut (
      .clk(clk), .reset(reset),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
      .in_row_first(in_row_first), .in_row_start(in_row_start),
      .in_row_pixel(in_row_pixel), .in_col_start(in_col_start),
      .in_col_index(in_col_index), .cursor_enable(cursor_enable),
      .cursor_row(cursor_row), .cursor_col(cursor_col),
      .vram_ce(vram_ce), .vram_row(vram_row), .vram_col(vram_col),
      .vram_data(vram_data), .rom_ce(rom_ce), .rom_char(rom_char),
      .rom_row(rom_row), .rom_q(rom_q),
      .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
   );

   // Environment memories: text buffer and glyph ROM, one-clock read latency.
   logic [15:0] vram [0:ROWS-1][0:COLS-1];

   function automatic logic [CHAR_W-1:0] glyph(input logic [7:0] ch, input logic [PIX_BITS-1:0] ln);
      if (ch == 8'h41) return 10'b1100000000;
      if (ch == 8'h00) return '0;
      return {ch[4:0] ^ ln, ch[7:3]};
   endfunction

   always @(posedge clk) begin
      if (vram_ce) vram_data <= vram[vram_row][vram_col];
      if (rom_ce)  rom_q     <= glyph(rom_char, rom_row);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [18:0] val;
      int          tag;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit sb_on    = 1'b0;
   int cur_tag  = 0;

   // Reference model state
   int m_row   = 0;
   int m_frame = 0;
   bit m_phase = 1'b1;

   function automatic logic [4:0] c5(input logic i, input logic on);
      if (!on) return 5'h00;
      return i ? 5'h1F : 5'h10;
   endfunction

   function automatic logic [5:0] c6(input logic i, input logic on);
      if (!on) return 6'h00;
      return i ? 6'h3F : 6'h20;
   endfunction

   function automatic logic [15:0] pix_rgb(input int row, input int col, input int line, input int x);
      logic [15:0]       w;
      logic [CHAR_W-1:0] g;
      logic              on;
      logic              cur;
      logic [3:0]        irgb;
      w   = vram[row][col];
      g   = glyph(w[7:0], line[PIX_BITS-1:0]);
      on  = g[CHAR_W-1-x];
      cur = cursor_enable && (row == int'(cursor_row)) && (col == int'(cursor_col)) &&
            m_phase && (line >= CHAR_H - 2);
      on  = on ^ cur;
      if (w[15] && !m_phase) on = 1'b0;
      irgb = on ? w[11:8] : {1'b0, w[14:12]};
      return {c5(irgb[3], irgb[2]), c6(irgb[3], irgb[1]), c5(irgb[3], irgb[0])};
   endfunction

   // One input cycle: drive, update the model, queue the expected output.
   task automatic drive(input int hs, input int vs, input int de, input int first,
                        input int start, input int pix, input int cs, input int col,
                        input logic [15:0] rgb);
      in_hsync     = hs[0];
      in_vsync     = vs[0];
      in_de        = de[0];
      in_row_first = first[0];
      in_row_start = start[0];
      in_row_pixel = pix[PIX_BITS-1:0];
      in_col_start = cs[0];
      in_col_index = col[COL_BITS-1:0];
      if (first != 0) begin
         m_row = 0;
         if (m_frame == BLINK_FRAMES - 1) begin
            m_frame = 0;
            m_phase = !m_phase;
         end else begin
            m_frame++;
         end
      end else if (start != 0 && m_row < ROWS - 1) begin
         m_row++;
      end
      if (sb_on)
         q.push_back('{due: cyc + 4, val: {hs[0], vs[0], de[0], (de != 0) ? rgb : 16'h0000}, tag: cur_tag});
      @(posedge clk);
      #1;
   endtask

   task automatic row_pulse(input int first, input int start);
      drive(0, 1, 0, first, start, 0, 0, 0, 16'h0000);
   endtask

   task automatic drive_line(input int line, input int first_col, input int ncells);
      int cs;
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, line, 0, 0, 16'h0000);
      for (int c = 0; c < ncells; c++) begin
         for (int x = 0; x < CHAR_W; x++) begin
            cs = (x == 0) ? 1 : 0;
            drive(0, 0, 1, 0, 0, line, cs, first_col + c, pix_rgb(m_row, first_col + c, line, x));
         end
      end
      for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, line, 0, 0, 16'h0000);
   endtask

   task automatic apply_reset();
      sb_on = 1'b0;
      reset = 1'b1;
      q.delete();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      reset   = 1'b0;
      m_row   = 0;
      m_frame = 0;
      m_phase = 1'b1;
      sb_on   = 1'b1;
   endtask

   task automatic monitor();
      exp_t        e;
      logic [18:0] act;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            act = {lcd_hsync, lcd_vsync, lcd_de, lcd_r, lcd_g, lcd_b};
            n_checks++;
            if (act !== e.val) begin
               n_fail++;
               $display("FAIL lcd_out tag=%0d cyc=%0d got=%h expected=%h", e.tag, cyc, act, e.val);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] obs [12];
      string       nm  [12];
      cur_tag = 1;
      sb_on   = 1'b0;
      reset   = 1'b1;
      cursor_enable = 1'b1;
      for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 1, 31, 1, 127, 16'h0000);
      @(negedge clk);
      nm  = '{"vram_ce", "vram_row", "vram_col", "rom_ce", "rom_char", "rom_row",
              "lcd_hsync", "lcd_vsync", "lcd_de", "lcd_r", "lcd_g", "lcd_b"};
      obs = '{32'(vram_ce), 32'(vram_row), 32'(vram_col), 32'(rom_ce), 32'(rom_char),
              32'(rom_row), 32'(lcd_hsync), 32'(lcd_vsync), 32'(lcd_de), 32'(lcd_r),
              32'(lcd_g), 32'(lcd_b)};
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (obs[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_%s got=%h expected=0", nm[i], obs[i]);
         end
      end
      @(posedge clk);
      #1;
      cursor_enable = 1'b0;
      reset   = 1'b0;
      m_row   = 0;
      m_frame = 0;
      m_phase = 1'b1;
      sb_on   = 1'b1;
   endtask

   task automatic test_single_cell();
      cur_tag = 2;
      vram[0][0] = 16'h0F41;
      drive_line(0, 0, 1);
      drive_line(7, 0, 1);
   endtask

   task automatic test_background();
      cur_tag = 3;
      vram[0][1] = 16'h1F00;
      drive_line(3, 1, 1);
   endtask

   task automatic test_back_to_back();
      cur_tag = 4;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            vram[r][c] = 16'($urandom);
      row_pulse(1, 0);
      for (int r = 0; r < 4; r++) begin
         if (r > 0) row_pulse(0, 1);
         drive_line(0, 0, 8);
         drive_line(r * 5 % CHAR_H, 0, 8);
      end
   endtask

   task automatic test_blink();
      cur_tag = 5;
      apply_reset();
      vram[0][0] = 16'h8F41;
      vram[0][1] = 16'h9C41;
      vram[0][2] = 16'h0F41;
      for (int i = 0; i < 29; i++) row_pulse(1, 0);
      drive_line(0, 0, 3);
      row_pulse(1, 0);
      cur_tag = 6;
      drive_line(0, 0, 3);
      drive_line(9, 0, 3);
      for (int i = 0; i < 30; i++) row_pulse(1, 0);
      cur_tag = 7;
      drive_line(2, 0, 3);
   endtask

   task automatic test_cursor();
      cur_tag = 8;
      cursor_enable = 1'b1;
      cursor_row    = 5'd2;
      cursor_col    = 7'd5;
      for (int c = 0; c < 8; c++) begin
         vram[2][c] = 16'h0A00;
         vram[3][c] = 16'h2A00;
      end
      vram[2][5] = 16'h1E00;
      row_pulse(1, 0);
      row_pulse(0, 1);
      row_pulse(0, 1);
      for (int l = 12; l < CHAR_H; l++) drive_line(l, 0, 8);
      row_pulse(0, 1);
      drive_line(15, 0, 8);
      cursor_enable = 1'b0;
   endtask

   task automatic test_row_saturation();
      cur_tag = 9;
      row_pulse(1, 0);
      for (int i = 0; i < 40; i++) begin
         row_pulse(0, 1);
         if (i == 28) begin
            n_checks++;
            if (vram_row !== 5'd29) begin
               n_fail++;
               $display("FAIL row_reach got=%0d expected=29", vram_row);
            end
         end
      end
      n_checks++;
      if (vram_row !== 5'd29) begin
         n_fail++;
         $display("FAIL row_saturate got=%0d expected=29", vram_row);
      end
      row_pulse(1, 1);
      n_checks++;
      if (vram_row !== 5'd0) begin
         n_fail++;
         $display("FAIL row_first_priority got=%0d expected=0", vram_row);
      end
   endtask

   task automatic test_reset_mid_line();
      logic [45:0] outs;
      cur_tag = 10;
      apply_reset();
      for (int i = 0; i < 30; i++) row_pulse(1, 0);
      vram[0][0] = 16'h8F41;
      vram[0][1] = 16'h0F41;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      for (int x = 0; x < 5; x++)
         drive(0, 0, 1, 0, 0, 0, (x == 0) ? 1 : 0, 0, pix_rgb(m_row, 0, 0, x));
      sb_on = 1'b0;
      reset = 1'b1;
      q.delete();
      drive(1, 1, 1, 0, 0, 0, 1, 1, 16'h0000);
      outs = {vram_ce, vram_row, vram_col, rom_ce, rom_char, rom_row,
              lcd_hsync, lcd_vsync, lcd_de, lcd_r, lcd_g, lcd_b};
      n_checks++;
      if (outs !== 46'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs got=%h expected=0", outs);
      end
      reset   = 1'b0;
      m_row   = 0;
      m_frame = 0;
      m_phase = 1'b1;
      sb_on   = 1'b1;
      cur_tag = 11;
      drive_line(0, 0, 2);
   endtask

   initial begin
      reset = 1'b1;
      in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
      in_row_first = 1'b0; in_row_start = 1'b0; in_row_pixel = '0;
      in_col_start = 1'b0; in_col_index = '0;
      cursor_enable = 1'b0; cursor_row = '0; cursor_col = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            vram[r][c] = 16'h0000;
      fork
         monitor();
      join_none
      @(posedge clk);
      #1;
      test_reset();
      test_single_cell();
      test_background();
      test_back_to_back();
      test_blink();
      test_cursor();
      test_row_saturation();
      test_reset_mid_line();
      for (int i = 0; i < 8; i++) @(posedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/text_render.md
TEXT_RENDER -- requirements
Module: text_render

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  COLS 80 -- text columns.
  ROWS 30 -- text rows.
  CHAR_W 10 -- glyph width in pixels.
  CHAR_H 16 -- glyph height in pixel lines.
  COL_BITS 7 -- column index width.
  ROW_BITS 5 -- row index width.
  PIX_BITS 5 -- glyph pixel-row width.
  BLINK_FRAMES 30 -- frames per blink half-period.
REQ-002 Ports (name, direction, width, meaning), one per line; one clock, reset synchronous active-high:
  clk  in  1  pixel clock.
  reset  in  1  synchronous active-high reset.
  in_hsync, in_vsync, in_de  in  1 each  timing from the vga generator.
  in_row_first  in  1  pulse on the first pixel row of the frame.
  in_row_start  in  1  pulse when a new text row begins.
  in_row_pixel  in  PIX_BITS  glyph line within the row.
  in_col_start  in  1  pulse at the first pixel of each cell.
  in_col_index  in  COL_BITS  cell column.
  cursor_enable  in  1  cursor visible.
  cursor_row  in  ROW_BITS  cursor cell row.
  cursor_col  in  COL_BITS  cursor cell column.
  vram_ce  out  1  vram read strobe.
  vram_row  out  ROW_BITS  vram read row.
  vram_col  out  COL_BITS  vram read column.
  vram_data  in  16  [7:0] char, [11:8] fg IRGB, [14:12] bg RGB, [15] blink; valid 1 cycle after vram_ce.
  rom_ce  out  1  glyph ROM read strobe.
  rom_char  out  8  glyph ROM character code.
  rom_row  out  PIX_BITS  glyph ROM line.
  rom_q  in  CHAR_W  glyph bits, MSB leftmost; valid 1 cycle after rom_ce.
  lcd_hsync, lcd_vsync, lcd_de  out  1 each  delayed timing.
  lcd_r  out  5  red.
  lcd_g  out  6  green.
  lcd_b  out  5  blue.

Function
REQ-003 Fixed latency of 4 clk from in_* timing to lcd_hsync/lcd_vsync/lcd_de and the matching pixel colour.
REQ-004 Row counter: in_row_first sets it to 0; otherwise in_row_start increments it, saturating at ROWS-1; in_row_first wins over a simultaneous in_row_start.
REQ-005 Stage 1 (registered): vram_ce = delayed in_col_start; vram_row = row counter; vram_col = delayed in_col_index.
REQ-006 Stage 2: rom_ce = stage-1 col_start delayed 1 clk; rom_char = vram_data[7:0]; rom_row = in_row_pixel delayed 2 clk; attributes, cursor-hit flag and row_pixel are captured from vram_data and carried to stage 3.
REQ-007 Cursor hit: stage-1 row equals cursor_row and stage-1 col equals cursor_col.
REQ-008 Stage 4 shift register (CHAR_W bits): loads rom_q when stage-3 col_start is high; otherwise shifts left, filling with 0. Attributes and cursor-hit reload on the same edge.
REQ-009 Pixel = shift MSB, XOR cursor term; cursor term = cursor_enable & hit & blink_phase & (row_pixel >= CHAR_H-2).
REQ-010 Blink attribute set and blink_phase low: the pixel is forced to background.
REQ-011 Colour mapping for IRGB {i,r,g,b}:
  r set -> lcd_r = i ? 5'h1F : 5'h10, else 0.
  g set -> lcd_g = i ? 6'h3F : 6'h20, else 0.
  b set -> lcd_b follows the red rule.
  Background uses i=0.
REQ-012 lcd_r/g/b = 0 whenever stage-4 de is low.
REQ-013 Blink: frame counter increments on each in_row_first pulse; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
REQ-014 Counter widths are sized by $clog2(BLINK_FRAMES); no truncation for defaults.

Reset
REQ-015 While reset is high: all outputs, all pipeline registers and the shift register are 0, row counter 0, frame counter 0, blink_phase 1; the first valid output appears 4 clk after reset deasserts.
REQ-016 Reset asserted mid-line takes effect on the next clk edge and discards in-flight pixels.

Verification
REQ-017 Single cell: vram_data=16'h0F41, rom_q=10'b1100000000, de high -> lcd pixels 0-1 = R1F/G3F/B1F, pixels 2-9 = 0; first pixel appears 4 clk after in_col_start.
REQ-018 Background: vram_data=16'h1F00, rom_q=0 -> all 10 pixels R0/G0/B10.
REQ-019 Blink: 30 in_row_first pulses -> blink_phase toggles; a cell with attr[15]=1 shows only background during the off phase.
REQ-020 Cursor: cursor_enable=1 at (2,5), rom_q=0 -> pixel rows 14-15 of cell (2,5) show fg during the on phase; all other cells are unchanged.
REQ-021 Row saturation and priority: 40 in_row_start pulses -> vram_row holds 29; in_row_first together with in_row_start -> vram_row = 0.
REQ-022 Reset mid-frame -> next cycle all outputs 0 and blink_phase 1.
